// File: rtl/jericalla_sequencer_if.sv
// Handshake bundle between the host and the Jericalla sequencer:
// the instruction push port and the captured result port.
interface jericalla_sequencer_if #(
    parameter int IW = 17,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_zf;

    modport master (
        output in_valid, in_instr, res_ready,
        input  in_ready, res_valid, res_data, res_zf
    );

    modport slave (
        input  in_valid, in_instr, res_ready,
        output in_ready, res_valid, res_data, res_zf
    );
endinterface

// File: rtl/jericalla_sequencer.sv
// Jericalla sequencer: buffers instructions in a FIFO, issues them one at a
// time to the datapath, waits a settle time, captures DS/zf and hands the
// result to the consumer. Can halt the stream when a captured zf is set.
module jericalla_sequencer #(
    parameter int IW     = 17,
    parameter int DW     = 32,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jericalla_sequencer_if.slave  bus,
    output logic [IW-1:0]         dp_instr_o,
    input  logic [DW-1:0]         dp_ds_i,
    input  logic                  dp_zf_i,
    input  logic                  halt_on_zero_i,
    input  logic                  resume_i,
    output logic                  halted_o,
    output logic                  busy_o,
    output logic [15:0]           issued_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [AW:0]   FULL_CNT    = (AW+1)'(DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;
    localparam logic [2:0] ST_HALT    = 3'd5;

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, fifo_empty, fifo_full;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] dp_instr_q, dp_instr_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_zf_q, res_zf_d;
    logic [15:0]   issued_q, issued_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    // The only pop happens on the IDLE->ISSUE transition.
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    // A pop frees a slot this cycle, so a push is still taken when full.
    assign bus.in_ready = !fifo_full || pop;
    assign push         = bus.in_valid && bus.in_ready;

    // FIFO storage: contents need no reset, pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_instr;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state logic for the issue/settle/capture/output sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dp_instr_d  = dp_instr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zf_d    = res_zf_q;
        issued_d    = issued_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    dp_instr_d = mem_q[rd_ptr_q];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = SETTLE_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_data_d  = dp_ds_i;
                res_zf_d    = dp_zf_i;
                res_valid_d = 1'b1;
                issued_d    = issued_q + 16'd1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = (halt_on_zero_i && res_zf_q) ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: begin
                if (resume_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers; reset discards any pending result at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dp_instr_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zf_q    <= 1'b0;
            issued_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dp_instr_q  <= dp_instr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zf_q    <= res_zf_d;
            issued_q    <= issued_d;
        end
    end

    assign dp_instr_o    = dp_instr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zf    = res_zf_q;
    assign halted_o      = (state_q == ST_HALT);
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
    assign issued_cnt_o  = issued_q;

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Directed bench for the Jericalla sequencer with a small combinational
// stand-in for the datapath (DS and zf derived from the instruction).
module tb_jericalla_sequencer;

    localparam int IW = 17;
    localparam int DW = 32;
    localparam int SETTLE = 2;
    localparam logic [IW-1:0] T2 = 17'b00110010010001101;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] dp_instr;
    logic [DW-1:0] dp_ds;
    logic          dp_zf;
    logic          halt_on_zero;
    logic          resume;
    logic          halted;
    logic          busy;
    logic [15:0]   issued_cnt;

    int vectors;
    int miscompares;

    jericalla_sequencer_if #(.IW(IW), .DW(DW)) bus ();

    jericalla_sequencer #(.IW(IW), .DW(DW), .DEPTH(8), .SETTLE(SETTLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .dp_instr_o    (dp_instr),
        .dp_ds_i       (dp_ds),
        .dp_zf_i       (dp_zf),
        .halt_on_zero_i(halt_on_zero),
        .resume_i      (resume),
        .halted_o      (halted),
        .busy_o        (busy),
        .issued_cnt_o  (issued_cnt)
    );

    function automatic logic [DW-1:0] ds_model(input logic [IW-1:0] i);
        if (i == T2) return 32'h0000_1234;
        return {15'd0, i} ^ 32'hA5A5_0000;
    endfunction

    assign dp_ds = ds_model(dp_instr);
    assign dp_zf = (dp_instr[16:14] == 3'b101);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.res_ready = 1'b1;
        halt_on_zero = 1'b0;
        resume       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [IW-1:0] v);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = v;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_res();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) break;
        end
        vectors++;
        if (bus.res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL res_valid_timeout: got %b expected 1", bus.res_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 8;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        if (dp_instr !== '0) begin miscompares++; $display("FAIL rst_dp_instr: got %h expected 0", dp_instr); end
        if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid: got %b expected 0", bus.res_valid); end
        if (bus.res_data !== '0) begin miscompares++; $display("FAIL rst_res_data: got %h expected 0", bus.res_data); end
        if (bus.res_zf !== 1'b0) begin miscompares++; $display("FAIL rst_res_zf: got %b expected 0", bus.res_zf); end
        if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b expected 0", halted); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (issued_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_issued: got %0d expected 0", issued_cnt); end
        // Get into SETTLE with one more entry queued, then reset asynchronously.
        push(17'h0_1111);
        push(17'h0_2222);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors += 7;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
        if (dp_instr !== '0) begin miscompares++; $display("FAIL midrst_dp_instr: got %h expected 0", dp_instr); end
        if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_res_valid: got %b expected 0", bus.res_valid); end
        if (bus.res_data !== '0) begin miscompares++; $display("FAIL midrst_res_data: got %h expected 0", bus.res_data); end
        if (halted !== 1'b0) begin miscompares++; $display("FAIL midrst_halted: got %b expected 0", halted); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (issued_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_issued: got %0d expected 0", issued_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors += 3;
        if (dp_instr !== '0) begin miscompares++; $display("FAIL postrst_dp_instr: got %h expected 0", dp_instr); end
        if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL postrst_res_valid: got %b expected 0", bus.res_valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL postrst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        push(T2);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dp_instr !== T2) begin miscompares++; $display("FAIL single_dp_instr: got %h expected %h", dp_instr, T2); end
        for (int i = 0; i < SETTLE + 1; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b expected 0 at cycle %0d", bus.res_valid, i + 1); end
        end
        @(negedge clk);
        vectors += 4;
        if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", bus.res_valid); end
        if (bus.res_data !== 32'h0000_1234) begin miscompares++; $display("FAIL single_data: got %h expected 00001234", bus.res_data); end
        if (bus.res_zf !== 1'b0) begin miscompares++; $display("FAIL single_zf: got %b expected 0", bus.res_zf); end
        if (issued_cnt !== 16'd1) begin miscompares++; $display("FAIL single_issued: got %0d expected 1", issued_cnt); end
        @(negedge clk);
        vectors++;
        if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL single_drop: got %b expected 0", bus.res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] seq [6];
        seq[0] = {3'b000, 14'h0011};
        seq[1] = {3'b001, 14'h0122};
        seq[2] = {3'b010, 14'h0233};
        seq[3] = {3'b110, 14'h1344};
        seq[4] = {3'b111, 14'h2455};
        seq[5] = {3'b100, 14'h3566};
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) push(seq[i]);
            end
            begin
                int k = 0;
                int held = 0;
                logic [IW-1:0] prev = dp_instr;
                logic prev_v = 1'b0;
                for (int c = 0; c < 150 && k < 6; c++) begin
                    @(negedge clk);
                    if (dp_instr === prev) held++;
                    else begin held = 1; prev = dp_instr; end
                    if (bus.res_valid === 1'b1 && prev_v === 1'b0) begin
                        vectors += 4;
                        if (dp_instr !== seq[k]) begin miscompares++; $display("FAIL b2b_instr[%0d]: got %h expected %h", k, dp_instr, seq[k]); end
                        if (held < SETTLE) begin miscompares++; $display("FAIL b2b_hold[%0d]: got %0d cycles expected >= %0d", k, held, SETTLE); end
                        if (bus.res_data !== ds_model(seq[k])) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, bus.res_data, ds_model(seq[k])); end
                        if (bus.res_zf !== 1'b0) begin miscompares++; $display("FAIL b2b_zf[%0d]: got %b expected 0", k, bus.res_zf); end
                        k++;
                    end
                    prev_v = bus.res_valid;
                end
                vectors++;
                if (k != 6) begin miscompares++; $display("FAIL b2b_count: got %0d results expected 6", k); end
            end
        join
        repeat (4) @(negedge clk);
        vectors += 2;
        if (issued_cnt !== 16'd6) begin miscompares++; $display("FAIL b2b_issued: got %0d expected 6", issued_cnt); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fifo_full();
        logic [IW-1:0] exp_q [9];
        logic [IW-1:0] z  = {3'b101, 14'h0007};
        logic [IW-1:0] x9 = 17'h0ABCD;
        for (int i = 0; i < 8; i++) exp_q[i] = {3'b010, 14'(i * 3 + 5)};
        exp_q[8] = 17'h1F0F0;
        do_reset();
        halt_on_zero = 1'b1;
        push(z);
        wait_res();
        @(negedge clk);
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("FAIL full_halted: got %b expected 1", halted); end
        for (int i = 0; i < 8; i++) push(exp_q[i]);
        @(negedge clk);
        vectors += 2;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b expected 0", bus.in_ready); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL full_busy: got %b expected 1", busy); end
        // Ninth push while full and halted must be dropped.
        bus.in_valid = 1'b1;
        bus.in_instr = x9;
        @(negedge clk);
        bus.in_instr = exp_q[8];
        resume       = 1'b1;
        halt_on_zero = 1'b0;
        @(negedge clk);
        resume = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors += 2;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_after_pushpop: got %b expected 0", bus.in_ready); end
        if (dp_instr !== exp_q[0]) begin miscompares++; $display("FAIL full_first_issue: got %h expected %h", dp_instr, exp_q[0]); end
        for (int k = 0; k < 9; k++) begin
            wait_res();
            vectors++;
            if (bus.res_data !== ds_model(exp_q[k])) begin miscompares++; $display("FAIL full_drain[%0d]: got %h expected %h", k, bus.res_data, ds_model(exp_q[k])); end
        end
        repeat (8) @(negedge clk);
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL full_drain_busy: got %b expected 0", busy); end
        if (issued_cnt !== 16'd10) begin miscompares++; $display("FAIL full_issued: got %0d expected 10", issued_cnt); end
    endtask

    task automatic test_halt();
        logic [IW-1:0] z = {3'b101, 14'h0042};
        logic [IW-1:0] a = {3'b001, 14'h0777};
        do_reset();
        halt_on_zero = 1'b1;
        push(z);
        push(a);
        wait_res();
        vectors += 2;
        if (bus.res_zf !== 1'b1) begin miscompares++; $display("FAIL halt_zf: got %b expected 1", bus.res_zf); end
        if (bus.res_data !== ds_model(z)) begin miscompares++; $display("FAIL halt_data: got %h expected %h", bus.res_data, ds_model(z)); end
        @(negedge clk);
        vectors += 2;
        if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_enter: got %b expected 1", halted); end
        if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL halt_res_valid: got %b expected 0", bus.res_valid); end
        repeat (8) @(negedge clk);
        vectors += 4;
        if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_hold: got %b expected 1", halted); end
        if (dp_instr !== z) begin miscompares++; $display("FAIL halt_no_issue: got %h expected %h", dp_instr, z); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL halt_busy: got %b expected 1", busy); end
        if (issued_cnt !== 16'd1) begin miscompares++; $display("FAIL halt_issued: got %0d expected 1", issued_cnt); end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        vectors++;
        if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_resume: got %b expected 0", halted); end
        @(negedge clk);
        vectors++;
        if (dp_instr !== a) begin miscompares++; $display("FAIL halt_next_issue: got %h expected %h", dp_instr, a); end
        wait_res();
        vectors += 2;
        if (bus.res_data !== ds_model(a)) begin miscompares++; $display("FAIL halt_next_data: got %h expected %h", bus.res_data, ds_model(a)); end
        if (bus.res_zf !== 1'b0) begin miscompares++; $display("FAIL halt_next_zf: got %b expected 0", bus.res_zf); end
        // A resume pulse outside HALT must not disturb the pending result.
        bus.res_ready = 1'b0;
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        vectors += 2;
        if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL halt_stray_resume_valid: got %b expected 1", bus.res_valid); end
        if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_stray_resume_halted: got %b expected 0", halted); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL halt_final_valid: got %b expected 0", bus.res_valid); end
        if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_final_halted: got %b expected 0", halted); end
        if (issued_cnt !== 16'd2) begin miscompares++; $display("FAIL halt_final_issued: got %0d expected 2", issued_cnt); end
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] b = {3'b110, 14'h0ACE};
        do_reset();
        bus.res_ready = 1'b0;
        push(b);
        wait_res();
        vectors++;
        if (bus.res_data !== ds_model(b)) begin miscompares++; $display("FAIL bp_data: got %h expected %h", bus.res_data, ds_model(b)); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors += 4;
            if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.res_valid); end
            if (bus.res_data !== ds_model(b)) begin miscompares++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, bus.res_data, ds_model(b)); end
            if (bus.res_zf !== 1'b0) begin miscompares++; $display("FAIL bp_hold_zf[%0d]: got %b expected 0", i, bus.res_zf); end
            if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy[%0d]: got %b expected 1", i, busy); end
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b expected 0", bus.res_valid); end
        if (issued_cnt !== 16'd1) begin miscompares++; $display("FAIL bp_issued: got %0d expected 1", issued_cnt); end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_idle: got %b expected 0", busy); end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.res_ready = 1'b1;
        halt_on_zero = 1'b0;
        resume       = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_halt();
        test_fifo_full();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
